// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  // funct3 encoding of the M-extension ops.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Control FSM states of the unit.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } md_state_e;

  // Working width of the helpers; callers cast their XLEN values in and out.
  localparam int MD_MAX_W = 64;
  typedef logic [MD_MAX_W-1:0] md_word_t;

  // Two's-complement negate when neg is set. Used both for taking the
  // magnitude of a negative operand and for re-applying a sign.
  function automatic md_word_t abs_val(input md_word_t v, input logic neg);
    return neg ? (~v + md_word_t'(1)) : v;
  endfunction

  // rs1 is interpreted as signed for this op.
  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as signed for this op (mulhsu keeps rs2 unsigned).
  function automatic logic op2_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// (and kill is low). in_ready is high only while the unit is idle; the
// requester holds in_valid and its payload until it transfers, and requests
// seen while busy are simply ignored. out_valid is a one-cycle pulse with no
// back-pressure; result/tag_out stay stable until the next pulse.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic [TAG_W-1:0] tag_in;
  logic             kill;
  logic             out_valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  // Pipeline side issuing operations.
  modport master (
    output in_valid, op, op1, op2, tag_in, kill,
    input  in_ready, out_valid, result, tag_out
  );

  // Unit side.
  modport slave (
    input  in_valid, op, op1, op2, tag_in, kill,
    output in_ready, out_valid, result, tag_out
  );
endinterface

// File: rtl/muldiv_divider_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// cycle, XLEN cycles after start. The quotient is shifted into the dividend
// register as dividend bits are consumed.
module muldiv_divider_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);
  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  dsr_q;
  logic [XLEN-1:0]  rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    trial;

  // Next partial remainder candidate and trial subtraction.
  assign rem_shift = {rem_q, dvd_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dsr_q};

  // Load on start, then one restoring step per cycle until the count runs out.
  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
    end else if (start_i) begin
      dvd_q  <= dividend_i;
      dsr_q  <= divisor_i;
      rem_q  <= '0;
      cnt_q  <= CNT_W'(XLEN - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (!trial[XLEN]) begin
        rem_q <= trial[XLEN-1:0];
      end else begin
        rem_q <= rem_shift[XLEN-1:0];
      end
      dvd_q <= {dvd_q[XLEN-2:0], ~trial[XLEN]};
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

  // done_o marks the cycle whose closing edge performs the last step.
  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = dvd_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit. Owns the control FSM, divide
// special-case detection, the multiplier delay line and the final sign fix;
// the iterative divide datapath lives in muldiv_divider_core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   bus,
  output md_state_e state_o
);
  localparam int              CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};

  // FSM and registered outputs.
  md_state_e        state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_out_q;
  logic [CNT_W-1:0] mul_cnt_q;

  // Per-op context captured at accept.
  logic [TAG_W-1:0] tag_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             rem_sel_q;

  // Request decode.
  md_op_e          op_in;
  logic            accept;
  logic            op1_neg;
  logic            op2_neg;
  logic            div_zero;
  logic            div_ovf;
  logic            div_special;
  logic [XLEN-1:0] special_res;

  assign op_in   = md_op_e'(bus.op);
  assign accept  = bus.in_valid && in_ready_q && !bus.kill;
  assign op1_neg = is_signed_op(op_in) && bus.op1[XLEN-1];
  assign op2_neg = op2_is_signed(op_in) && bus.op2[XLEN-1];

  // Divide corner cases are resolved at accept and skip the divider.
  assign div_zero    = (bus.op2 == '0);
  assign div_ovf     = !bus.op[0] && (bus.op1 == XMIN) && (bus.op2 == '1);
  assign div_special = bus.op[2] && (div_zero || div_ovf);

  // Architectural result for the divide corner cases.
  always_comb begin
    special_res = '1;
    if (div_zero) begin
      special_res = bus.op[1] ? bus.op1 : '1;
    end else if (div_ovf) begin
      special_res = bus.op[1] ? '0 : XMIN;
    end
  end

  // Multiplier: extend each operand per op signedness to 2*XLEN bits; the
  // product modulo 2^(2*XLEN) then holds the correct high and low halves.
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_sel;
  logic [XLEN-1:0]   mul_pipe_q [MUL_LAT];

  assign mul_a    = {{XLEN{op1_neg}}, bus.op1};
  assign mul_b    = {{XLEN{op2_neg}}, bus.op2};
  assign mul_prod = mul_a * mul_b;
  assign mul_sel  = (bus.op[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                           : mul_prod[2*XLEN-1:XLEN];

  // Delay line giving the product MUL_LAT cycles to settle; stage 0 is the
  // product of the accepted request, last stage is read on entry to DONE.
  always_ff @(posedge clk) begin
    mul_pipe_q[0] <= mul_sel;
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

  // Divider runs on magnitudes; signs are re-applied in DIV_FIX.
  logic            div_start;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            div_done;

  assign div_start    = accept && bus.op[2] && !div_special;
  assign div_dividend = XLEN'(abs_val(md_word_t'(bus.op1), op1_neg));
  assign div_divisor  = XLEN'(abs_val(md_word_t'(bus.op2), op2_neg));

  muldiv_divider_core #(
    .XLEN (XLEN)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .abort_i     (bus.kill),
    .dividend_i  (div_dividend),
    .divisor_i   (div_divisor),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // Signed fix-up: quotient negated when operand signs differ, remainder
  // follows the dividend's sign.
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  assign quo_fixed = XLEN'(abs_val(md_word_t'(div_quo), quo_neg_q));
  assign rem_fixed = XLEN'(abs_val(md_word_t'(div_rem), rem_neg_q));

  // Capture per-op context when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (accept) begin
      tag_q     <= bus.tag_in;
      quo_neg_q <= op1_neg ^ op2_neg;
      rem_neg_q <= op1_neg;
      rem_sel_q <= bus.op[1];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_out_q   <= '0;
      mul_cnt_q   <= '0;
    end else if (bus.kill && (state_q != ST_IDLE)) begin
      // Abort: back to idle without a result; result/tag_out keep old values.
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (!bus.op[2]) begin
              state_q   <= ST_MUL_WAIT;
              mul_cnt_q <= CNT_W'(MUL_LAT - 1);
            end else if (div_special) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= special_res;
              tag_out_q   <= bus.tag_in;
            end else begin
              state_q <= ST_DIV_RUN;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (mul_cnt_q == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_pipe_q[MUL_LAT-1];
            tag_out_q   <= tag_q;
          end else begin
            mul_cnt_q <= mul_cnt_q - CNT_W'(1);
          end
        end
        ST_DIV_RUN: begin
          if (div_done) begin
            state_q <= ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
          result_q    <= rem_sel_q ? rem_fixed : quo_fixed;
          tag_out_q   <= tag_q;
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.tag_out   = tag_out_q;
  assign state_o       = state_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit for the execute stage. It implements the full RV32M op set, which the single-cycle ALU currently returns as zero. The unit is parametrised in operand width and multiplier latency, and accepts one operation at a time through a valid/ready handshake. The result is returned with a destination tag, and the pipeline stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width in bits (must be even, >=8)
MUL_LAT, 2, multiply latency in cycles from acceptance to result (>=1)
TAG_W, 5, width of the pass-through destination tag

Ports:
clk  in  1  clock
rst  in  1  reset (see Behaviour)
in_valid  in  1  operation request
in_ready  out  1  unit can accept (high only in IDLE)
op  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
op1  in  XLEN  rs1 value
op2  in  XLEN  rs2 value
tag_in  in  TAG_W  destination register tag
kill  in  1  flush; aborts the in-flight op
out_valid  out  1  one-cycle result pulse
result  out  XLEN  result, held until the next out_valid
tag_out  out  TAG_W  tag of the result, held with result

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE, in_ready=1, out_valid=0, result=0, tag_out=0. Reset mid-operation discards the op with no out_valid.
- Accept: an op is accepted when in_valid && in_ready at a rising edge. Call that cycle 0. Operands, op and tag are latched, and in_ready drops from cycle 1.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE.
- IDLE -> MUL_WAIT when op[2]=0.
- IDLE -> DIV_RUN when op[2]=1 and neither special case applies.
- IDLE -> DONE for a divide special case.
- MUL_WAIT: counter runs MUL_LAT cycles (cycles 1..MUL_LAT), then DONE. out_valid is high in cycle MUL_LAT+1.
- Multiply math: 2*XLEN-bit product. Operands are sign-extended per op: mulh both signed, mulhsu op1 signed and op2 unsigned, mulhu both unsigned. mul returns the low XLEN bits; the others return the high XLEN bits.
- DIV_RUN: restoring division on absolute values, one quotient bit per cycle, XLEN cycles (1..XLEN).
- DIV_FIX: one cycle (XLEN+1) applying signs. Quotient is negated if the operand signs differ (signed ops only). Remainder takes the dividend's sign.
- DONE: out_valid=1 for exactly one cycle (XLEN+2 for normal divides), then IDLE. in_ready returns the following cycle.
- Divide special cases (decided at accept, result in DONE at cycle 1):
  - Divide by zero: div/divu -> all ones; rem/remu -> op1.
  - Signed overflow (op1=MIN, op2=-1): div -> MIN; rem -> 0.
- kill: any state except IDLE -> IDLE next edge. No out_valid is produced, and result/tag_out keep their old values.
  - kill in DONE suppresses nothing: out_valid is already asserted that cycle.
  - kill with in_valid in IDLE: the op is not accepted.
- result and tag_out update only on the edge entering DONE.
- in_valid while busy is ignored. The requester must hold the request; no queueing.

Decomposition:
- Shared package muldiv_pkg:
  - op enum (MD_MUL..MD_REMU, 3 bits)
  - state enum
  - helper functions abs_val and is_signed_op
- One sub-module, muldiv_divider_core: iterative restoring divider datapath (remainder/quotient shift registers, iteration counter, start/done).
- The top level owns the FSM, special-case detection, multiplier delay line and sign fix.

Test Plan:
- XLEN=32, MUL_LAT=2: mul 7*(-3) at cycle 0 -> out_valid cycle 3, result 0xFFFFFFEB, tag_out=tag_in. in_ready low in cycles 1-3.
- mulh/mulhsu/mulhu with op1=op2=0x80000000 -> 0x40000000 / 0xC0000000 / 0x40000000.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/7 -> 14. out_valid exactly at cycle 34, single pulse.
- divu 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000/-1 -> 0x80000000 and rem -> 0. All at cycle 1.
- div started, kill at cycle 10 -> no out_valid, previous result held, in_ready=1 at cycle 11. A next mul is accepted normally.
- rst asserted at cycle 5 of a divide -> all outputs at reset values next cycle. in_valid during busy cycles is ignored, with no extra out_valid.
